// File: rtl/lsu_bus_if_pkg.sv
// Shared RV32I load/store definitions: funct3 width codes and LSU bus FSM states.
package lsu_bus_if_pkg;

  localparam int unsigned F3_W = 3;

  localparam logic [F3_W-1:0] F3_B  = 3'b000;
  localparam logic [F3_W-1:0] F3_H  = 3'b001;
  localparam logic [F3_W-1:0] F3_W32 = 3'b010;
  localparam logic [F3_W-1:0] F3_BU = 3'b100;
  localparam logic [F3_W-1:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: legality check, byte enables, store replication, load shift.
module lsu_align
  import lsu_bus_if_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned BYTES = XLEN / 8
) (
  input  logic             mem_write,
  input  logic [F3_W-1:0]  funct3,
  input  logic [1:0]       addr_lo,
  input  logic [XLEN-1:0]  wdata,
  input  logic [1:0]       roff,
  input  logic [XLEN-1:0]  rdata_raw,
  output logic             legal,
  output logic [BYTES-1:0] be,
  output logic [XLEN-1:0]  wdata_lane,
  output logic [XLEN-1:0]  rdata_shift
);

  always_comb begin
    legal      = 1'b0;
    be         = '1;
    wdata_lane = wdata;
    if (mem_write) begin
      case (funct3)
        F3_B: begin
          legal      = 1'b1;
          be         = BYTES'(1) << addr_lo;
          wdata_lane = {BYTES{wdata[7:0]}};
        end
        F3_H: begin
          legal      = ~addr_lo[0];
          be         = BYTES'(3) << addr_lo;
          wdata_lane = {(BYTES/2){wdata[15:0]}};
        end
        F3_W32:  legal = (addr_lo == 2'b00);
        default: legal = 1'b0;
      endcase
    end else begin
      case (funct3)
        F3_B, F3_BU: legal = 1'b1;
        F3_H, F3_HU: legal = ~addr_lo[0];
        F3_W32:      legal = (addr_lo == 2'b00);
        default:     legal = 1'b0;
      endcase
    end
  end

  // Addressed byte lands in bits 7:0; extension happens downstream.
  assign rdata_shift = rdata_raw >> {roff, 3'b000};

endmodule

// File: rtl/lsu_bus_if.sv
// Load/store unit to single-beat memory bus bridge with pipeline stall handshake.
module lsu_bus_if
  import lsu_bus_if_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned BYTES = XLEN / 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             memReq,
  input  logic             memWrite,
  input  logic [F3_W-1:0]  funct3,
  input  logic [XLEN-1:0]  addr,
  input  logic [XLEN-1:0]  wData,
  output logic             stall,
  output logic             done,
  output logic             fault,
  output logic [XLEN-1:0]  rData,
  output logic             busReq,
  output logic             busWe,
  output logic [XLEN-1:0]  busAddr,
  output logic [BYTES-1:0] busBe,
  output logic [XLEN-1:0]  busWData,
  input  logic             busGnt,
  input  logic             busRValid,
  input  logic [XLEN-1:0]  busRData
);

  localparam int unsigned OFF_W = 2;

  lsu_state_e       state_q, state_d;
  logic             accept;
  logic             legal;
  logic [BYTES-1:0] be_c;
  logic [XLEN-1:0]  wlane_c;
  logic [XLEN-1:0]  rshift_c;
  logic [OFF_W-1:0] roff_q;

  lsu_align #(.XLEN(XLEN), .BYTES(BYTES)) u_align (
    .mem_write   (memWrite),
    .funct3      (funct3),
    .addr_lo     (addr[OFF_W-1:0]),
    .wdata       (wData),
    .roff        (roff_q),
    .rdata_raw   (busRData),
    .legal       (legal),
    .be          (be_c),
    .wdata_lane  (wlane_c),
    .rdata_shift (rshift_c)
  );

  // Next state plus the two combinational handshake outputs.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    stall   = 1'b0;
    fault   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (memReq && legal) begin
          accept  = 1'b1;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: if (busGnt) state_d = busWe ? ST_DONE : ST_WAIT;
      ST_WAIT:   if (busRValid) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    stall = rst_n && (accept || (state_q == ST_ACCESS) || (state_q == ST_WAIT));
    fault = rst_n && (state_q == ST_IDLE) && memReq && !legal;
  end

  // State, registered bus fields and load result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      done     <= 1'b0;
      busReq   <= 1'b0;
      busWe    <= 1'b0;
      busAddr  <= '0;
      busBe    <= '0;
      busWData <= '0;
      roff_q   <= '0;
      rData    <= '0;
    end else begin
      state_q <= state_d;
      done    <= (state_d == ST_DONE);
      busReq  <= (state_d == ST_ACCESS);
      if (accept) begin
        busWe    <= memWrite;
        busAddr  <= {addr[XLEN-1:OFF_W], OFF_W'(0)};
        busBe    <= be_c;
        busWData <= wlane_c;
        roff_q   <= addr[OFF_W-1:0];
      end else if ((state_q == ST_ACCESS) && busGnt) begin
        busWe    <= 1'b0;
        busAddr  <= '0;
        busBe    <= '0;
        busWData <= '0;
      end
      if ((state_q == ST_WAIT) && busRValid) rData <= rshift_c;
    end
  end

endmodule

// File: tb/tb_lsu_bus_if.sv
// Scoreboard bench for lsu_bus_if: driver pushes expected outcomes, monitor checks bus/done/fault.
module tb_lsu_bus_if;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        memReq = 1'b0;
  logic        memWrite = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = '0;
  logic [31:0] wData = '0;
  logic        stall, done, fault;
  logic [31:0] rData;
  logic        busReq, busWe;
  logic [31:0] busAddr;
  logic [3:0]  busBe;
  logic [31:0] busWData;
  logic        busGnt = 1'b0;
  logic        busRValid = 1'b0;
  logic [31:0] busRData = '0;

  lsu_bus_if #(.XLEN(32), .BYTES(4)) dut (
    .clk(clk), .rst_n(rst_n), .memReq(memReq), .memWrite(memWrite),
    .funct3(funct3), .addr(addr), .wData(wData), .stall(stall), .done(done),
    .fault(fault), .rData(rData), .busReq(busReq), .busWe(busWe),
    .busAddr(busAddr), .busBe(busBe), .busWData(busWData), .busGnt(busGnt),
    .busRValid(busRValid), .busRData(busRData)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_fault;
    logic [31:0] baddr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] last_rd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: bus fields every ACCESS cycle, completions on done/fault pulses.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (busReq) begin
        if (sb.size() == 0) chk("unexpected_busreq", 32'(busReq), 32'd0);
        else begin
          e = sb[0];
          chk("busAddr", busAddr, e.baddr);
          chk("busBe", 32'(busBe), 32'(e.be));
          chk("busWe", 32'(busWe), 32'(e.we));
          if (e.we) chk("busWData", busWData, e.wdata);
        end
      end
      if (fault) begin
        if (sb.size() == 0) chk("unexpected_fault", 32'(fault), 32'd0);
        else begin
          e = sb.pop_front();
          chk("fault_expected", 32'(e.is_fault), 32'd1);
        end
      end
      if (done) begin
        if (sb.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
        else begin
          e = sb.pop_front();
          chk("done_not_fault", 32'(e.is_fault), 32'd0);
          chk("rData", rData, e.rdata);
        end
      end
    end
  end

  task automatic do_load(input logic [31:0] a, input logic [2:0] f3, input int ngnt,
                         input logic [31:0] rd, input logic [31:0] exp_baddr,
                         input logic [31:0] exp_rd);
    @(posedge clk); #1;
    memReq = 1'b1; memWrite = 1'b0; funct3 = f3; addr = a; wData = 32'h0;
    sb.push_back('{1'b0, exp_baddr, 4'hF, 1'b0, 32'h0, exp_rd});
    last_rd = exp_rd;
    @(negedge clk) chk("stall_req", 32'(stall), 32'd1);
    @(posedge clk); #1 memReq = 1'b0;
    repeat (ngnt) begin
      @(negedge clk) chk("stall_gnt_wait", 32'(stall), 32'd1);
      @(posedge clk); #1;
    end
    busGnt = 1'b1;
    @(negedge clk) chk("stall_access", 32'(stall), 32'd1);
    @(posedge clk); #1 busGnt = 1'b0; busRValid = 1'b1; busRData = rd;
    @(negedge clk) chk("stall_wait", 32'(stall), 32'd1);
    @(posedge clk); #1 busRValid = 1'b0;
    @(negedge clk) chk("stall_done", 32'(stall), 32'd0);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [2:0] f3, input int ngnt,
                          input logic [31:0] wd, input logic [31:0] exp_baddr,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd);
    @(posedge clk); #1;
    memReq = 1'b1; memWrite = 1'b1; funct3 = f3; addr = a; wData = wd;
    sb.push_back('{1'b0, exp_baddr, exp_be, 1'b1, exp_wd, last_rd});
    @(negedge clk) chk("stall_req", 32'(stall), 32'd1);
    @(posedge clk); #1 memReq = 1'b0;
    repeat (ngnt) begin
      @(negedge clk) chk("stall_gnt_wait", 32'(stall), 32'd1);
      @(posedge clk); #1;
    end
    busGnt = 1'b1;
    @(posedge clk); #1 busGnt = 1'b0;
    @(negedge clk) chk("stall_done", 32'(stall), 32'd0);
  endtask

  task automatic do_fault(input logic [31:0] a, input logic [2:0] f3, input logic we);
    @(posedge clk); #1;
    memReq = 1'b1; memWrite = we; funct3 = f3; addr = a; wData = 32'h1234_5678;
    sb.push_back('{1'b1, 32'h0, 4'h0, we, 32'h0, last_rd});
    @(negedge clk);
    chk("fault_stall", 32'(stall), 32'd0);
    chk("fault_busreq", 32'(busReq), 32'd0);
    @(posedge clk); #1 memReq = 1'b0;
    @(negedge clk);
    chk("fault_busreq_after", 32'(busReq), 32'd0);
    chk("fault_pulse_end", 32'(fault), 32'd0);
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_busReq"}, 32'(busReq), 32'd0);
    chk({tag, "_busWe"}, 32'(busWe), 32'd0);
    chk({tag, "_busAddr"}, busAddr, 32'd0);
    chk({tag, "_busBe"}, 32'(busBe), 32'd0);
    chk({tag, "_busWData"}, busWData, 32'd0);
    chk({tag, "_rData"}, rData, 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_fault"}, 32'(fault), 32'd0);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk) chk_idle_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    do_load(32'h100, 3'b010, 0, 32'hDEADBEEF, 32'h100, 32'hDEADBEEF);
    do_store(32'h103, 3'b000, 0, 32'h0000_00A5, 32'h100, 4'b1000, 32'hA5A5A5A5);
    do_load(32'h202, 3'b001, 0, 32'h8765ABCD, 32'h200, 32'h0000_8765);
    do_fault(32'h101, 3'b010, 1'b0);
    do_load(32'h400, 3'b010, 4, 32'h12345678, 32'h400, 32'h12345678);
    do_store(32'h006, 3'b001, 2, 32'h0000_BEEF, 32'h004, 4'b1100, 32'hBEEFBEEF);
    do_store(32'h008, 3'b010, 0, 32'hCAFEF00D, 32'h008, 4'b1111, 32'hCAFEF00D);
    do_load(32'h011, 3'b100, 1, 32'h11223344, 32'h010, 32'h0011_2233);
    do_fault(32'h005, 3'b001, 1'b1);
    do_fault(32'h003, 3'b101, 1'b0);
    do_fault(32'h000, 3'b011, 1'b0);
    do_fault(32'h000, 3'b100, 1'b1);
    do_fault(32'h00A, 3'b010, 1'b1);

    // Reset while waiting for read data; the late beat must be dropped.
    @(posedge clk); #1;
    memReq = 1'b1; memWrite = 1'b0; funct3 = 3'b010; addr = 32'h300;
    sb.push_back('{1'b0, 32'h300, 4'hF, 1'b0, 32'h0, 32'h0});
    @(posedge clk); #1 memReq = 1'b0; busGnt = 1'b1;
    @(posedge clk); #1 busGnt = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; sb.delete(); last_rd = 32'h0;
    @(negedge clk) chk_idle_zero("wait_reset");
    @(posedge clk); #1 busRValid = 1'b1; busRData = 32'h5555_5555;
    @(posedge clk); #1 busRValid = 1'b0;
    @(negedge clk);
    chk("stale_rData", rData, 32'd0);
    chk("stale_done", 32'(done), 32'd0);
    @(negedge clk) chk("stale_done2", 32'(done), 32'd0);

    do_load(32'h000, 3'b000, 0, 32'h0000_00FF, 32'h000, 32'h0000_00FF);
    repeat (2) @(posedge clk);
    chk("queue_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lsu_bus_if.md
LSU_BUS_IF -- requirements
Module: lsu_bus_if

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width.
REQ-002 SHALL have parameter BYTES, default 4, byte lanes per word (XLEN/8).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 memReq  input  1  memory-stage access valid.
REQ-006 memWrite  input  1  1 = store, 0 = load.
REQ-007 funct3  input  3  RV32I load/store width code.
REQ-008 addr  input  XLEN  byte address.
REQ-009 wData  input  XLEN  store data, right-aligned.
REQ-010 stall  output  1  hold pipeline.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 fault  output  1  one-cycle misaligned/illegal-access pulse.
REQ-013 rData  output  XLEN  loaded word shifted so addressed byte is bits 7:0; not extended (downstream load extension does that).
REQ-014 busReq, busWe  output  1 each  bus request / write.
REQ-015 busAddr  output  XLEN  word-aligned address (bits 1:0 = 0).
REQ-016 busBe  output  BYTES  byte enables.
REQ-017 busWData  output  XLEN  lane-replicated store data.
REQ-018 busGnt  input  1  bus accepted request this cycle.
REQ-019 busRValid, busRData  input  1, XLEN  read data return.

Function
REQ-020 FSM states IDLE, ACCESS, WAIT, DONE.
REQ-021 IDLE: memReq and legal access -> capture addr/funct3/memWrite/wData, go ACCESS; stall=1 that cycle.
REQ-022 Illegal: lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]!=0; load funct3 011/110/111; store funct3 >010 -> fault=1 combinationally in IDLE, stall=0, no bus activity, stay IDLE.
REQ-023 ACCESS: busReq=1 with captured fields held stable until busGnt; on busGnt store -> DONE, load -> WAIT.
REQ-024 WAIT: on busRValid -> rData <= busRData >> (8*addr[1:0]), go DONE; busRValid in ACCESS or IDLE ignored.
REQ-025 DONE: done=1, stall=0, -> IDLE; back-to-back request starts next cycle in IDLE.
REQ-026 stall=1 in ACCESS and WAIT, also IDLE when accepting.
REQ-027 busBe: sb 0001<<addr[1:0]; sh 0011<<addr[1:0]; sw 1111; loads 1111.
REQ-028 busWData: sb {4{wData[7:0]}}; sh {2{wData[15:0]}}; sw wData.
REQ-029 Minimum load latency: request cycle to done = 3 cycles (gnt in first ACCESS cycle, rvalid next cycle).
REQ-030 rData holds last load value until next load completes; stores do not alter it.

Reset
REQ-031 rst_n low at any edge, any state -> IDLE; busReq, busWe, busBe, busAddr, busWData, rData, done, fault, stall all 0 next cycle.
REQ-032 In-flight transaction abandoned on reset; subsequent stale busRValid ignored in IDLE.

Structure
REQ-033 funct3 load/store codes and FSM state encodings SHALL live in the shared RV32I defines file.
REQ-034 One sub-module lsu_align: combinational busBe/busWData generation, read shift, legality check.

Verification
REQ-035 lw addr 0x100, gnt cycle 1, rvalid 0xDEADBEEF cycle 2 -> done cycle 3, rData=0xDEADBEEF, stall 1,1,0.
REQ-036 sb addr 0x103 wData 0x000000A5 -> busAddr 0x100, busBe 1000, busWData 0xA5A5A5A5, done after gnt, rData unchanged.
REQ-037 lh addr 0x202, rvalid 0x8765ABCD -> rData=0x00008765.
REQ-038 lw addr 0x101 -> fault=1 one cycle, busReq never asserted, stall=0.
REQ-039 gnt delayed 4 cycles -> busReq and fields stable all 4 cycles, stall held.
REQ-040 rst_n low in WAIT, rvalid arrives after -> IDLE, done never pulses, rData=0.
